// File: rtl/led_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_if
// Purpose  : Control/display bundle between a controller and the LED sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface led_seq_if #(
    parameter int LED_W = 8
);
    logic [1:0]       mode;
    logic             pause;
    logic             step_btn;
    logic [LED_W-1:0] led;
    logic             tick;
    logic             dir;

    modport master (
        output mode, pause, step_btn,
        input  led, tick, dir
    );

    modport slave (
        input  mode, pause, step_btn,
        output led, tick, dir
    );
endinterface
`default_nettype wire

// File: rtl/led_seq.sv
`default_nettype none
// ============================================================================
// Module   : led_seq
// Purpose  : LED pattern sequencer (rotate L/R, bounce, count) with prescaled
//            auto-step, pause and a synchronised single-step button.
// Revision : 1.0 - initial release
// ============================================================================
module led_seq #(
    parameter int LED_W  = 8,
    parameter int unsigned PERIOD = 500000
) (
    input  wire logic clk,
    input  wire logic rst,
    led_seq_if.slave  bus
);

    localparam logic [1:0]  c_mode_rol    = 2'd0;
    localparam logic [1:0]  c_mode_ror    = 2'd1;
    localparam logic [1:0]  c_mode_bounce = 2'd2;
    localparam logic [1:0]  c_mode_count  = 2'd3;
    localparam logic [31:0] c_cnt_last    = 32'(PERIOD - 1);

    logic [31:0]      cnt_q, cnt_d;
    logic [LED_W-1:0] pat_q, pat_d, pat_step;
    logic             dir_q, dir_d, dir_step;
    logic             tick_q, tick_d;
    logic [1:0]       mode_q, mode_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic             cnt_wrap, mstep, step;

    // Next pattern/direction if a step were taken this cycle.
    always_comb begin : p_step_fn
        pat_step = pat_q;
        dir_step = dir_q;
        unique case (mode_q)
            c_mode_rol: pat_step = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            c_mode_ror: pat_step = {pat_q[0], pat_q[LED_W-1:1]};
            c_mode_bounce: begin
                if (!dir_q) begin
                    pat_step = pat_q << 1;
                    if (pat_step[LED_W-1]) dir_step = 1'b1;
                end else begin
                    pat_step = pat_q >> 1;
                    if (pat_step[0]) dir_step = 1'b0;
                end
            end
            default: pat_step = pat_q + LED_W'(1);
        endcase
    end

    always_comb begin : p_next
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        mode_d = mode_q;
        s1_d   = bus.step_btn;
        s2_d   = s1_q;
        s3_d   = s2_q;

        cnt_wrap = (cnt_q == c_cnt_last);
        mstep    = s2_q & ~s3_q;
        step     = (!bus.pause && cnt_wrap) || (bus.pause && mstep);

        if (!bus.pause) begin
            cnt_d = cnt_wrap ? 32'd0 : cnt_q + 32'd1;
        end

        // A mode change restarts the sequence and overrides any step.
        if (bus.mode != mode_q) begin
            mode_d = bus.mode;
            cnt_d  = 32'd0;
            dir_d  = 1'b0;
            pat_d  = (bus.mode == c_mode_count) ? '0 : LED_W'(1);
        end else if (step) begin
            pat_d  = pat_step;
            dir_d  = dir_step;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            cnt_q  <= 32'd0;
            pat_q  <= LED_W'(1);
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
            mode_q <= bus.mode;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
            mode_q <= mode_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
        end
    end

    assign bus.led  = pat_q;
    assign bus.tick = tick_q;
    assign bus.dir  = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_led_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_seq
// Purpose  : Bench for led_seq: three configurations against a step-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned W_A [3] = '{8, 4, 3};
    int unsigned P_A [3] = '{4, 2, 1};

    logic        rst_a   [3];
    logic [1:0]  mode_a  [3];
    logic        pause_a [3];
    logic        btn_a   [3];
    logic [31:0] led_a   [3];
    logic        tick_a  [3];
    logic        dir_a   [3];

    led_seq_if #(.LED_W(8)) if0 ();
    led_seq_if #(.LED_W(4)) if1 ();
    led_seq_if #(.LED_W(3)) if2 ();

    led_seq #(.LED_W(8), .PERIOD(4)) u0 (.clk(clk), .rst(rst_a[0]), .bus(if0.slave));
    led_seq #(.LED_W(4), .PERIOD(2)) u1 (.clk(clk), .rst(rst_a[1]), .bus(if1.slave));
    led_seq #(.LED_W(3), .PERIOD(1)) u2 (.clk(clk), .rst(rst_a[2]), .bus(if2.slave));

    assign if0.mode = mode_a[0]; assign if0.pause = pause_a[0]; assign if0.step_btn = btn_a[0];
    assign if1.mode = mode_a[1]; assign if1.pause = pause_a[1]; assign if1.step_btn = btn_a[1];
    assign if2.mode = mode_a[2]; assign if2.pause = pause_a[2]; assign if2.step_btn = btn_a[2];
    assign led_a[0] = 32'(if0.led); assign tick_a[0] = if0.tick; assign dir_a[0] = if0.dir;
    assign led_a[1] = 32'(if1.led); assign tick_a[1] = if1.tick; assign dir_a[1] = if1.dir;
    assign led_a[2] = 32'(if2.led); assign tick_a[2] = if2.tick; assign dir_a[2] = if2.dir;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the display is a pure function of the number of steps taken since
    // the last reload; steps fall every PERIOD unpaused cycles or on a button
    // edge seen two edges late while paused.
    bit          m_valid [3];
    logic [1:0]  m_mode  [3];
    int unsigned m_n     [3];
    int unsigned m_u     [3];
    int unsigned m_base  [3];
    logic        m_tick  [3];
    logic [2:0]  m_hist  [3];
    bit          ms, st;

    function automatic logic [31:0] exp_led(int i);
        int unsigned w, n, k, pos;
        w = W_A[i];
        n = m_n[i];
        case (m_mode[i])
            2'd0: return 32'd1 << (n % w);
            2'd1: return 32'd1 << ((w - (n % w)) % w);
            2'd2: begin
                k   = n % (2 * w - 2);
                pos = (k <= w - 1) ? k : (2 * w - 2 - k);
                return 32'd1 << pos;
            end
            default: return 32'((m_base[i] + n) % (32'd1 << w));
        endcase
    endfunction

    function automatic logic exp_dir(int i);
        int unsigned w;
        w = W_A[i];
        if (m_mode[i] != 2'd2) return 1'b0;
        return ((m_n[i] % (2 * w - 2)) >= (w - 1));
    endfunction

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst_a[i]) begin
                m_valid[i] = 1'b1;
                m_mode[i]  = mode_a[i];
                m_n[i]     = 0;
                m_u[i]     = 0;
                m_base[i]  = 1;
                m_tick[i]  = 1'b0;
                m_hist[i]  = 3'b000;
            end else if (m_valid[i]) begin
                ms        = m_hist[i][1] & ~m_hist[i][2];
                m_hist[i] = {m_hist[i][1:0], btn_a[i]};
                if (mode_a[i] != m_mode[i]) begin
                    m_mode[i] = mode_a[i];
                    m_n[i]    = 0;
                    m_u[i]    = 0;
                    m_base[i] = 0;
                    m_tick[i] = 1'b0;
                end else begin
                    st = ms & pause_a[i];
                    if (!pause_a[i]) begin
                        m_u[i]++;
                        if (m_u[i] % P_A[i] == 0) st = 1'b1;
                    end
                    if (st) m_n[i]++;
                    m_tick[i] = st;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (m_valid[i]) begin
                chk($sformatf("u%0d.led", i),  led_a[i],        exp_led(i));
                chk($sformatf("u%0d.tick", i), 32'(tick_a[i]),  32'(m_tick[i]));
                chk($sformatf("u%0d.dir", i),  32'(dir_a[i]),   32'(exp_dir(i)));
            end
        end
    end

    task automatic wait_tick(int i, int budget, output logic [31:0] l);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!tick_a[i] && c < budget);
        chk($sformatf("u%0d.tick_seen", i), 32'(tick_a[i]), 32'd1);
        l = led_a[i];
    endtask

    logic [31:0] l;
    logic [31:0] rol_exp [8] = '{32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h40, 32'h80, 32'h01};
    logic [31:0] bnc_exp [7] = '{32'h2, 32'h4, 32'h8, 32'h4, 32'h2, 32'h1, 32'h2};
    logic        bnc_dir [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] up_exp  [4] = '{32'h02, 32'h04, 32'h08, 32'h10};
    logic [31:0] bo8_exp [8] = '{32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h40, 32'h80, 32'h40};

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1; mode_a[i] = 2'd0; pause_a[i] = 1'b0; btn_a[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.reset_led", i),  led_a[i],       32'd1);
            chk($sformatf("u%0d.reset_tick", i), 32'(tick_a[i]), 32'd0);
            rst_a[i] = 1'b0;
        end

        // Rotate left with wrap; tick never on two consecutive cycles.
        for (int j = 0; j < 8; j++) begin
            wait_tick(0, 10, l);
            chk("rol.led", l, rol_exp[j]);
            @(negedge clk);
            chk("rol.tick_gap", 32'(tick_a[0]), 32'd0);
        end

        // Advance to 0x10, then change mode as the prescaler is on its last count.
        for (int j = 0; j < 4; j++) begin
            wait_tick(0, 10, l);
            chk("rol2.led", l, up_exp[j]);
        end
        repeat (3) @(negedge clk);
        mode_a[0] = 2'd1;
        @(negedge clk);
        chk("mchg.led", led_a[0], 32'h01);
        chk("mchg.tick", 32'(tick_a[0]), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("mchg.next_tick", 32'(tick_a[0]), (c == 4) ? 32'd1 : 32'd0);
        end
        chk("mchg.next_led", led_a[0], 32'h80);

        // Paused manual step: held button gives one step, two edges after sampling.
        @(negedge clk);
        pause_a[0] = 1'b1;
        @(negedge clk);
        btn_a[0] = 1'b1;
        @(negedge clk);
        chk("man.k0", led_a[0], 32'h80);
        @(negedge clk);
        chk("man.k1", led_a[0], 32'h80);
        @(negedge clk);
        chk("man.k2_led", led_a[0], 32'h40);
        chk("man.k2_tick", 32'(tick_a[0]), 32'd1);
        repeat (7) begin
            @(negedge clk);
            chk("man.hold", {led_a[0][30:0], tick_a[0]}, {31'h40, 1'b0});
        end
        btn_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        pause_a[0] = 1'b0;
        @(negedge clk);
        btn_a[0] = 1'b1;
        repeat (10) @(negedge clk);
        btn_a[0] = 1'b0;

        // Pause on the final prescaler count suppresses the step until release.
        wait_tick(0, 10, l);
        repeat (3) @(negedge clk);
        pause_a[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("pause.no_tick", 32'(tick_a[0]), 32'd0);
        end
        pause_a[0] = 1'b0;
        @(negedge clk);
        chk("pause.release_tick", 32'(tick_a[0]), 32'd1);

        // Bounce up to the MSB and back, then reset with dir=1 and cnt=2.
        mode_a[0] = 2'd2;
        for (int j = 0; j < 8; j++) begin
            wait_tick(0, 10, l);
            chk("bnc8.led", l, bo8_exp[j]);
        end
        chk("bnc8.dir", 32'(dir_a[0]), 32'd1);
        repeat (2) @(negedge clk);
        rst_a[0] = 1'b1;
        @(negedge clk);
        chk("rst.led", led_a[0], 32'd1);
        chk("rst.dir", 32'(dir_a[0]), 32'd0);
        chk("rst.tick", 32'(tick_a[0]), 32'd0);
        rst_a[0] = 1'b0;

        // Bounce on a 4-wide bank.
        mode_a[1] = 2'd2;
        @(negedge clk);
        chk("bnc.start", led_a[1], 32'd1);
        for (int j = 0; j < 7; j++) begin
            wait_tick(1, 6, l);
            chk("bnc.led", l, bnc_exp[j]);
            chk("bnc.dir", 32'(dir_a[1]), 32'(bnc_dir[j]));
        end

        // Binary count on a 3-wide bank, one step per cycle.
        mode_a[2] = 2'd3;
        @(negedge clk);
        chk("cnt.start", led_a[2], 32'd0);
        chk("cnt.start_tick", 32'(tick_a[2]), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk("cnt.led", led_a[2], 32'(j % 8));
            chk("cnt.tick", 32'(tick_a[2]), 32'd1);
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_seq.md
# led_seq

Parametrised LED pattern sequencer for the board I/O top level. It generalises the fixed 8-bit rotating single-LED display in several ways: configurable LED width and step period, four selectable patterns (rotate left, rotate right, bounce, binary count), pause, and a synchronised single-step button. It drives the LED bank directly and exports a step strobe for other display logic.

## Interface
- `LED_W`, default 8: LED / pattern width; legal range 2..32.
- `PERIOD`, default 500000: clock cycles per automatic step; legal range 1..2^32-1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  pattern select: 0 rotate-left, 1 rotate-right, 2 bounce, 3 binary count. Synchronous level input.
- `pause`  in  1  level; when high, automatic stepping stops.
- `step_btn`  in  1  raw asynchronous button; rising edge gives one manual step while paused.
- `led`  out  LED_W  current pattern (registered).
- `tick`  out  1  registered one-cycle strobe; high in the cycle in which `led` shows a newly stepped value.
- `dir`  out  1  bounce direction (0 = toward MSB, 1 = toward LSB); registered.

## Operation
- **Registers**
  - `cnt`: 32-bit prescaler.
  - `pat`: LED_W bits; drives `led`.
  - `dir`.
  - `mode_q`: last accepted mode.
  - `s1`, `s2`, `s3`: button synchroniser and edge-detect chain.
- **Reset values**
  - `led` = 1 (LSB only).
  - `cnt` = 0.
  - `dir` = 0.
  - `tick` = 0.
  - `mode_q` = `mode` input at reset.
  - `s1` = `s2` = `s3` = 0.
- **Prescaler**
  - When `pause` = 0, `cnt` increments each cycle.
  - When `cnt` = PERIOD-1, `cnt` returns to 0 and an auto-step fires in that same cycle.
  - When `pause` = 1, `cnt` holds its value and no auto-steps fire.
- **Manual step**
  - `s1` <= `step_btn`, `s2` <= `s1`, `s3` <= `s2`.
  - `mstep` = `s2` & ~`s3`.
  - `mstep` advances the pattern only while `pause` = 1; otherwise it is ignored.
- **Step function**, applied to `pat` when a step fires:
  - Mode 0: `{pat[LED_W-2:0], pat[LED_W-1]}` (MSB wraps to LSB).
  - Mode 1: `{pat[0], pat[LED_W-1:1]}`.
  - Mode 2 (bounce), evaluated from the current `dir`:
    - `dir` = 0: shift left by 1. If the result has its MSB set, `dir` <= 1.
    - `dir` = 1: shift right by 1. If the result has its LSB set, `dir` <= 0.
    - Direction reverses on the same step that reaches the end, so the end LED is shown exactly once per sweep.
  - Mode 3: `pat` + 1 modulo 2^LED_W (all-ones wraps to 0).
- **Mode change**
  - If `mode` != `mode_q`, on that edge: `mode_q` <= `mode`, `cnt` <= 0, `dir` <= 0, `tick` <= 0.
  - `pat` <= 0 for mode 3, otherwise `pat` <= 1.
  - A mode change takes priority over any step in the same cycle.
- **Priority, highest first**
  1. `rst`
  2. mode change
  3. step
  4. hold
- Modes 0–2 assume a one-hot `pat`. A non-one-hot value (e.g. after leaving mode 3) cannot occur, because a mode change always reloads `pat`.

## Timing
- Auto-step: `tick` = 1 and the new `led` value are visible on the edge after the cycle with `cnt` = PERIOD-1. Steps are exactly PERIOD cycles apart.
- PERIOD = 1: a step fires every cycle, `cnt` stays 0, and `tick` is constantly high.
- Manual step latency:
  - `step_btn` is sampled high at edge k (previously low).
  - `mstep` is high during the cycle after edge k+1.
  - `led` and `tick` update at edge k+2.
  - Holding the button gives exactly one step. A new step requires a low sample first.
- Pause:
  - Asserting `pause` in the cycle where `cnt` = PERIOD-1 suppresses that step; `cnt` holds at PERIOD-1.
  - Deasserting `pause` lets the step fire on the next edge.
- Reset mid-operation: all registers return to their reset values on the next edge, regardless of mode, pause or button state.

## Test plan
- **Rotate left, wrap.** LED_W=8, PERIOD=4, reset, mode=0 → `led` goes 0x01, 0x02, …, 0x80, 0x01. `tick` pulses every 4 cycles and is never high for 2 consecutive cycles.
- **Bounce.** LED_W=4, PERIOD=2, mode=2 → `led` goes 1, 2, 4, 8, 4, 2, 1, 2. `dir` reads 1 after the step that produces 8 and 0 after the step that produces 1.
- **Count wrap.** LED_W=3, PERIOD=1, mode=3 → `led` goes 0, 1, …, 7, 0 on consecutive cycles. `tick` is constantly 1 after the mode switch settles.
- **Pause and manual step.** PERIOD=4, pause=1, hold `step_btn` high for 10 cycles → exactly one step, with `led` changing 2 edges after the first high sample. With pause=0, the same pulse changes nothing beyond normal auto-steps.
- **Mode change mid-sweep.** Mode 0 at `led` = 0x10, switch to mode 1 in the same cycle as `cnt` = PERIOD-1 → `led` = 0x01, `cnt` = 0, no `tick`. The next step comes PERIOD cycles later and gives `led` = 0x80.
- **Reset mid-run.** Assert `rst` while in mode 2 with `dir` = 1 and `cnt` = 2 → on the next edge `led` = 1, `dir` = 0, `cnt` = 0, `tick` = 0.
